load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 44 ++++
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Pipeline-facing and data-memory-facing signals of the load/store unit.
// The slave modport is the unit itself; the master modport is the pipeline plus memory side.
`ifndef XLEN
`define XLEN 32
`endif

interface load_store_unit_if #(
    parameter int XLEN = `XLEN
);
    logic            i_valid;
    logic            i_is_store;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] i_store_data;

    logic            or_ready;
    logic            or_done;
    logic [XLEN-1:0] or_load_data;
    logic            or_exc;
    logic [3:0]      or_exc_cause;
    logic [XLEN-1:0] or_exc_tval;

    logic            or_mem_req;
    logic [XLEN-1:0] or_mem_addr;
    logic [XLEN-1:0] or_mem_data;
    logic [2:0]      or_funct3;
    logic            or_read_write;
    logic            i_mem_ack;
    logic [XLEN-1:0] i_mem_data;

    modport slave (
        input  i_valid, i_is_store, i_funct3, i_addr, i_store_data,
        input  i_mem_ack, i_mem_data,
        output or_ready, or_done, or_load_data, or_exc, or_exc_cause, or_exc_tval,
        output or_mem_req, or_mem_addr, or_mem_data, or_funct3, or_read_write
    );

    modport master (
        output i_valid, i_is_store, i_funct3, i_addr, i_store_data,
        output i_mem_ack, i_mem_data,
        input  or_ready, or_done, or_load_data, or_exc, or_exc_cause, or_exc_tval,
        input  or_mem_req, or_mem_addr, or_mem_data, or_funct3, or_read_write
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: classifies one access, issues it to data memory,
// waits for an acknowledge with a bounded timeout and reports result or exception.
`ifndef XLEN
`define XLEN 32
`endif

module load_store_unit #(
    parameter int XLEN    = `XLEN,
    parameter int TIMEOUT = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    load_store_unit_if.slave lsu
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    // Legal encodings: LB/LH/LW/LBU/LHU for loads, SB/SH/SW for stores.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        logic ok;
        case (funct3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~is_store;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3[1:0])
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [7:0]      cnt_r;
    logic [7:0]      cnt_s;
    logic            accept_s;
    logic            exc_s;
    logic [3:0]      exc_cause_s;
    logic [XLEN-1:0] exc_tval_s;
    logic [XLEN-1:0] load_data_s;

    logic            is_store_r;
    logic [2:0]      funct3_r;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] store_data_r;
    logic            read_write_r;
    logic            ready_r;
    logic            done_r;
    logic            exc_r;
    logic [3:0]      exc_cause_r;
    logic [XLEN-1:0] exc_tval_r;
    logic [XLEN-1:0] load_data_r;
    logic            mem_req_r;

    // State register and REQ wait counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic plus the result that is captured when entering DONE.
    always_comb begin
        state_s     = state_r;
        cnt_s       = 8'd0;
        accept_s    = 1'b0;
        exc_s       = 1'b0;
        exc_cause_s = 4'd0;
        exc_tval_s  = {XLEN{1'b0}};
        load_data_s = {XLEN{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (lsu.i_valid) begin
                    accept_s = 1'b1;
                    if (!funct3_legal(lsu.i_is_store, lsu.i_funct3)) begin
                        state_s     = ST_DONE;
                        exc_s       = 1'b1;
                        exc_cause_s = 4'd2;
                        exc_tval_s  = lsu.i_addr;
                    end else if (misaligned(lsu.i_funct3, lsu.i_addr[1:0])) begin
                        state_s     = ST_DONE;
                        exc_s       = 1'b1;
                        exc_cause_s = lsu.i_is_store ? 4'd6 : 4'd4;
                        exc_tval_s  = lsu.i_addr;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // An acknowledge on the timeout edge still completes normally.
                if (lsu.i_mem_ack) begin
                    state_s     = ST_DONE;
                    load_data_s = is_store_r ? {XLEN{1'b0}} : lsu.i_mem_data;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_s     = ST_DONE;
                    exc_s       = 1'b1;
                    exc_cause_s = is_store_r ? 4'd7 : 4'd5;
                    exc_tval_s  = addr_r;
                end else begin
                    state_s = ST_REQ;
                    cnt_s   = cnt_r + 8'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, latched operation fields and held results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            is_store_r   <= 1'b0;
            funct3_r     <= 3'd0;
            addr_r       <= {XLEN{1'b0}};
            store_data_r <= {XLEN{1'b0}};
            read_write_r <= 1'b0;
            ready_r      <= 1'b1;
            done_r       <= 1'b0;
            exc_r        <= 1'b0;
            exc_cause_r  <= 4'd0;
            exc_tval_r   <= {XLEN{1'b0}};
            load_data_r  <= {XLEN{1'b0}};
            mem_req_r    <= 1'b0;
        end else begin
            ready_r   <= (state_s == ST_IDLE);
            done_r    <= (state_s == ST_DONE);
            mem_req_r <= (state_s == ST_REQ);
            exc_r     <= exc_s;
            if (accept_s) begin
                is_store_r   <= lsu.i_is_store;
                funct3_r     <= lsu.i_funct3;
                addr_r       <= lsu.i_addr;
                store_data_r <= lsu.i_store_data;
                read_write_r <= ~lsu.i_is_store;
            end
            // Results change only on entry to DONE and hold until the next one.
            if (state_s == ST_DONE) begin
                exc_cause_r <= exc_cause_s;
                exc_tval_r  <= exc_tval_s;
                load_data_r <= load_data_s;
            end
        end
    end

    assign lsu.or_ready      = ready_r;
    assign lsu.or_done       = done_r;
    assign lsu.or_exc        = exc_r;
    assign lsu.or_exc_cause  = exc_cause_r;
    assign lsu.or_exc_tval   = exc_tval_r;
    assign lsu.or_load_data  = load_data_r;
    assign lsu.or_mem_req    = mem_req_r;
    assign lsu.or_mem_addr   = addr_r;
    assign lsu.or_mem_data   = store_data_r;
    assign lsu.or_funct3     = funct3_r;
    assign lsu.or_read_write = read_write_r;

endmodule
